// File: rtl/key_pkg.sv
// key_pkg: default parameters and counter-width helper for key_debounce_led
package key_pkg;
  localparam int N_DEF = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one channel of synchroniser, stability counter, debounced level and event pulses
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic state,
  output logic nxt,
  output logic press,
  output logic rel
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s, done;
  assign s = sync[SYNC_STAGES-1];
  assign done = (s != state) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign nxt = done ? s : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      state <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ~key};
      cnt <= (s == state || done) ? '0 : cnt + 1'b1;
      state <= nxt;
      press <= done & s;
      rel <= done & ~s;
    end
  end
endmodule

// File: rtl/key_debounce_led.sv
// key_debounce_led: N-channel key debounce with press/release pulses and LED drive
// Define KEY_LED_TOGGLE_EN for toggle-on-press LEDs; otherwise LEDs follow the debounced level.
module key_debounce_led
  import key_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_state,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] led
);
  logic [N-1:0] nxt;
  for (genvar g = 0; g < N; g++) begin : ch
    key_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .key(key[g]),
      .state(key_state[g]),
      .nxt(nxt[g]),
      .press(key_press[g]),
      .rel(key_release[g])
    );
  end
  always_ff @(posedge clk) begin
`ifdef KEY_LED_TOGGLE_EN
    led <= rst ? '0 : led ^ (nxt & ~key_state);
`else
    led <= rst ? '0 : nxt;
`endif
  end
endmodule

// File: tb/tb_key_debounce_led.sv
// tb_key_debounce_led: scoreboard bench with a cycle model plus directed checks of key_debounce_led
module tb_key_debounce_led;
  localparam int N = 4;
  localparam int D = 8;
  logic clk = 0, rst = 1;
  logic [N-1:0] key = '1;
  logic [N-1:0] key_state, key_press, key_release, led;
  int n_tests = 0, n_fail = 0;
  logic [4*N-1:0] exp_q[$];
  logic [N-1:0] m_s1, m_s2, m_st, m_pr, m_rl, m_led;
  int m_cnt[N];
`ifdef KEY_LED_TOGGLE_EN
  localparam bit TOG = 1;
`else
  localparam bit TOG = 0;
`endif

  key_debounce_led #(.N(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .key(key), .key_state(key_state),
    .key_press(key_press), .key_release(key_release), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_pr = '0; m_rl = '0; m_led = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      m_pr = '0; m_rl = '0;
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] == m_st[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == D - 1) begin
          m_st[i] = m_s2[i];
          m_cnt[i] = 0;
          if (m_s2[i]) begin
            m_pr[i] = 1'b1;
            if (TOG) m_led[i] = ~m_led[i];
          end else m_rl[i] = 1'b1;
        end else m_cnt[i]++;
      end
      m_s2 = m_s1;
      m_s1 = ~key;
      if (!TOG) m_led = m_st;
    end
    exp_q.push_back({m_st, m_pr, m_rl, m_led});
  end

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk("model", 32'({key_state, key_press, key_release, led}), 32'(exp_q.pop_front()));
    else chk("queue_underflow", 32'd1, 32'd0);
  end

  initial begin
    bit exp_led;
    tick(2);
    chk("reset_outs", 32'({key_state, key_press, key_release, led}), 32'd0);
    rst = 0;
    tick(12);
    chk("idle_outs", 32'({key_state, key_press, key_release, led}), 32'd0);
    key[0] = 0;
    tick(9);
    chk("k0_before_e10", 32'(key_state[0]), 32'd0);
    tick(1);
    chk("k0_state_e10", 32'(key_state[0]), 32'd1);
    chk("k0_press_e10", 32'(key_press[0]), 32'd1);
    chk("k0_led_e10", 32'(led[0]), 32'd1);
    tick(1);
    chk("k0_press_one_cycle", 32'(key_press[0]), 32'd0);
    key[0] = 1;
    tick(12);
    key[1] = 0;
    tick(5);
    key[1] = 1;
    tick(20);
    chk("k1_bounce", 32'({key_state[1], led[1]}), 32'd0);
    key[3:2] = 2'b00;
    tick(10);
    chk("k32_press", 32'(key_press[3:2]), 32'b11);
    tick(10);
    key[3:2] = 2'b11;
    tick(10);
    chk("k32_release", 32'(key_release[3:2]), 32'b11);
    chk("k32_led", 32'(led[3:2]), TOG ? 32'b11 : 32'b00);
    tick(3);
    key[1] = 0;
    tick(7);
    rst = 1;
    tick(1);
    chk("rst_mid_outs", 32'({key_state, key_press, key_release, led}), 32'd0);
    rst = 0;
    tick(9);
    chk("k1_after_rst_early", 32'(key_state[1]), 32'd0);
    tick(1);
    chk("k1_after_rst_state", 32'(key_state[1]), 32'd1);
    chk("k1_after_rst_press", 32'(key_press[1]), 32'd1);
    key[1] = 1;
    tick(12);
    exp_led = 0;
    for (int k = 0; k < 3; k++) begin
      key[0] = 0;
      tick(10);
      exp_led = ~exp_led;
      chk("k0_led_press", 32'(led[0]), TOG ? 32'(exp_led) : 32'd1);
      key[0] = 1;
      tick(10);
      chk("k0_led_release", 32'(led[0]), TOG ? 32'(exp_led) : 32'd0);
    end
    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/key_debounce_led.md
# key_debounce_led

Parametrised N-channel push-button front end: synchronises active-low raw key inputs, debounces each channel with a stability counter, and produces a debounced level, one-cycle press/release pulses and an LED drive per channel. It sits directly between the board key pins and the LED pins, and also feeds debounced events to downstream control logic. It replaces plain invert-and-register key-to-LED paths.

## Interface
- `N`, 4, number of key/LED channels (≥1)
- `SYNC_STAGES`, 2, synchroniser flops per channel (≥2)
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles needed to accept a new level (≥2; 20 ms at 50 MHz)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `key`  in  N  raw key pins, active-low (0 = pressed), asynchronous to `clk`
- `key_state`  out  N  debounced level, 1 = pressed
- `key_press`  out  N  one-cycle pulse on accepted press
- `key_release`  out  N  one-cycle pulse on accepted release
- `led`  out  N  LED drive, 1 = on

## Operation
- Per channel: `~key[i]` enters a `SYNC_STAGES`-deep flop chain; the last stage is `s`.
- Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`, unsigned, never wraps.
- Each edge: if `s == key_state[i]`, then `cnt <= 0`. Else if `cnt == DEBOUNCE_CYCLES-1`, then `key_state[i] <= s` and `cnt <= 0`, and pulse. Else `cnt <= cnt+1`.
- Pulse: `key_press[i]` is 1 for exactly the cycle after `key_state[i]` goes 0→1. `key_release[i]` is 1 for the cycle after a 1→0 change. Both are registered. Press and release are never high together on one channel.
- Glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles: counter clears, and there is no change and no pulse.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- `led` is driven per the Configuration section.
- Reset (any time, including mid-count): sync flops, `cnt`, `key_state`, `key_press`, `key_release` and `led` all go to 0. A key held through reset is treated as a new press: it is accepted after the full latency and generates `key_press`.

## Timing
- Input change first sampled at edge e1, stable thereafter: `key_state` and `led` change at edge e(`SYNC_STAGES`+`DEBOUNCE_CYCLES`). `key_press`/`key_release` are high for the following cycle only.
- Defaults (2, 1_000_000): the change lands at edge 1_000_002.
- Outputs are all registered; there is no combinational path from `key` to any output.
- During the `rst=1` cycle's edge, all outputs are forced 0 regardless of inputs.

## Configuration
- `KEY_LED_TOGGLE_EN` defined: `led[i]` toggles on the same edge `key_state[i]` goes 0→1. Releases do not affect `led`. Reset clears `led` to off.
- Not defined: `led[i]` follows `key_state[i]` (register-equal), so the LED is on while the key is held. This preserves legacy key-to-LED behaviour with added debounce.

## Structure
- Package `key_pkg`: default values of `N`, `SYNC_STAGES` and `DEBOUNCE_CYCLES`, plus a counter-width helper constant.
- Sub-module `key_debounce_ch`: one channel containing sync chain, counter, state and pulse logic. It is instantiated N times in a generate loop.
- The top level holds the LED mode logic only.

## Test plan
Bench parameters: `N`=4, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=8.
- Reset with all keys released, `key`=4'b1111 → all outputs 0; no pulses afterwards.
- `key[0]` 1→0 held → `key_state[0]`=1 at edge 10 after first sample. `key_press[0]` high for exactly 1 cycle after that. `led[0]`=1.
- `key[1]` low for 5 cycles then high (bounce) → no change on any output of channel 1.
- Channels 2 and 3 pressed on the same edge, then released 20 cycles later → both `key_press` bits pulse in the same cycle, then both `key_release` bits. With `KEY_LED_TOGGLE_EN`, `led[3:2]` stays 2'b11 after release; without it, it returns to 2'b00.
- `rst` asserted at `cnt`=5 mid-debounce with the key still held → outputs 0 during reset. After reset is released, press is accepted 10 edges later with a fresh `key_press`.
- `KEY_LED_TOGGLE_EN`: three clean press/release cycles on `key[0]` → `led[0]` sequence 1, 0, 1, changing only on press acceptance.
